// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with holding register and error flags
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around the bit centre.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    input  logic                 rx_ack,
    output logic                 rx_busy,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int SP = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int DP = SP + 1;
`else
    localparam int DP = SP;
`endif
    localparam logic [CW-1:0] DP_C  = CW'(DP);
    localparam logic [CW-1:0] END_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic                 sync1, rxd_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, ferr_now;
    logic                 armed;
    logic                 commit;
    logic                 sample_bit;
    logic                 sample_pt, bit_end, last_data, last_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic maj_a, maj_b;

    // Votes from the two cycles before the decision point; the third vote is live rxd_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (cnt == CW'(SP - 1)) maj_a <= rxd_s;
            if (cnt == CW'(SP))     maj_b <= rxd_s;
        end
    end

    assign sample_bit = (maj_a & maj_b) | (maj_a & rxd_s) | (maj_b & rxd_s);
`else
    assign sample_bit = rxd_s;
`endif

    assign sample_pt = (cnt == DP_C);
    assign bit_end   = (cnt == END_C);
    assign last_data = (bit_idx == BW'(DATA_BITS - 1));
    assign last_stop = (int'(stop_idx) == STOP_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (!rxd_s && armed) state_n = S_START;
            S_START:  if (sample_pt && sample_bit) state_n = S_IDLE;
                      else if (bit_end) state_n = S_DATA;
            S_DATA:   if (bit_end && last_data)
                          state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_n = S_STOP;
            S_STOP:   if (sample_pt && last_stop) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy  = (state != S_IDLE);
        commit   = (state == S_STOP) && sample_pt && last_stop;
        ferr_now = ferr | ~sample_bit;
    end

    // armed blocks a new start after a commit until the line has been seen idle (break handling).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            if (state == S_IDLE || bit_end) cnt <= '0;
            else                            cnt <= cnt + CW'(1);

            if (commit)                      armed <= 1'b0;
            else if (state == S_IDLE && rxd_s) armed <= 1'b1;

            case (state)
                S_START: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                end
                S_DATA: begin
                    if (sample_pt) shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
                    if (bit_end && !last_data) bit_idx <= bit_idx + BW'(1);
                end
                S_PARITY: begin
                    if (sample_pt)
                        perr <= (PARITY_MODE == 1) ? (^shreg ^ sample_bit)
                                                   : ~(^shreg ^ sample_bit);
                end
                S_STOP: begin
                    if (sample_pt) ferr <= ferr_now;
                    if (bit_end)   stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_rx_data  <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else if (commit) begin
            uart_rx_data  <= shreg;
            rx_valid      <= 1'b1;
            rx_parity_err <= perr;
            rx_frame_err  <= ferr_now;
            rx_overrun    <= rx_valid && !rx_ack;
        end else if (rx_valid && rx_ack) begin
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param (three configurations)
module tb_uart_rx_param;

    localparam int N = 3;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    int cpb[N] = '{16, 16, 13};
    int db[N]  = '{8, 8, 7};
    int pm[N]  = '{0, 1, 2};
    int sb[N]  = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd[N];
    logic       ack[N];
    logic       busy[N], valid[N], perr[N], ferr[N], ovr[N];
    logic [7:0] data0, data1;
    logic [6:0] data2;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .rx_ack(ack[0]), .rx_busy(busy[0]),
        .uart_rx_data(data0), .rx_valid(valid[0]), .rx_parity_err(perr[0]),
        .rx_frame_err(ferr[0]), .rx_overrun(ovr[0]));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .rx_ack(ack[1]), .rx_busy(busy[1]),
        .uart_rx_data(data1), .rx_valid(valid[1]), .rx_parity_err(perr[1]),
        .rx_frame_err(ferr[1]), .rx_overrun(ovr[1]));
    uart_rx_param #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .rx_ack(ack[2]), .rx_busy(busy[2]),
        .uart_rx_data(data2), .rx_valid(valid[2]), .rx_parity_err(perr[2]),
        .rx_frame_err(ferr[2]), .rx_overrun(ovr[2]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         m_valid[N];
    logic [7:0] m_data[N];
    bit         m_perr[N], m_ferr[N], m_ovr[N];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int d);
        case (d)
            0:       return {24'd0, data0};
            1:       return {24'd0, data1};
            default: return {25'd0, data2};
        endcase
    endfunction

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            rxd[d] = 1'b1;
        end
    endtask

    task automatic check_out(input int d, input string tag);
        chk_eq($sformatf("%s.d%0d.valid", tag, d), {31'd0, valid[d]}, {31'd0, m_valid[d]});
        chk_eq($sformatf("%s.d%0d.data", tag, d), dat(d), {24'd0, m_data[d]});
        chk_eq($sformatf("%s.d%0d.perr", tag, d), {31'd0, perr[d]}, {31'd0, m_perr[d]});
        chk_eq($sformatf("%s.d%0d.ferr", tag, d), {31'd0, ferr[d]}, {31'd0, m_ferr[d]});
        chk_eq($sformatf("%s.d%0d.ovr", tag, d), {31'd0, ovr[d]}, {31'd0, m_ovr[d]});
        chk_eq($sformatf("%s.d%0d.busy", tag, d), {31'd0, busy[d]}, 32'd0);
    endtask

    // Reference: what the holding register must show after a frame commits.
    task automatic model_commit(input int d, input logic [7:0] word, input logic pbit,
                                input logic [1:0] stops, input bit ack_in_commit);
        logic [7:0] w;
        int         ones;
        w = word & 8'((1 << db[d]) - 1);
        ones = $countones(w) + int'(pbit);
        m_ovr[d]   = m_valid[d] && !ack_in_commit;
        m_valid[d] = 1'b1;
        m_data[d]  = w;
        m_perr[d]  = (pm[d] == 1) ? (ones % 2 != 0) : (pm[d] == 2) ? (ones % 2 != 1) : 1'b0;
        m_ferr[d]  = (stops[0] == 1'b0) || (sb[d] == 2 && stops[1] == 1'b0);
    endtask

    task automatic model_clear(input int d);
        m_valid[d] = 0; m_data[d] = 0; m_perr[d] = 0; m_ferr[d] = 0; m_ovr[d] = 0;
    endtask

    task automatic do_ack(input int d, input string tag);
        @(negedge clk);
        ack[d] = 1'b1;
        @(negedge clk);
        ack[d] = 1'b0;
        m_valid[d] = 0; m_perr[d] = 0; m_ferr[d] = 0; m_ovr[d] = 0;
        chk_eq($sformatf("%s.d%0d.ack_valid", tag, d), {31'd0, valid[d]}, 32'd0);
        chk_eq($sformatf("%s.d%0d.ack_ovr", tag, d), {31'd0, ovr[d]}, 32'd0);
    endtask

    // ack_cyc: cycle within the last stop bit to pulse rx_ack; rst_cyc: frame cycle to pulse rst.
    task automatic send_frame(input int d, input logic [7:0] word, input logic pbit,
                              input logic [1:0] stops, input int ack_cyc, input int rst_cyc,
                              input int spike_bit, input int spike_cyc);
        logic b[$];
        int   g;
        b.push_back(1'b0);
        for (int i = 0; i < db[d]; i++) b.push_back(word[i]);
        if (pm[d] != 0) b.push_back(pbit);
        for (int i = 0; i < sb[d]; i++) b.push_back(stops[i]);
        g = 0;
        for (int k = 0; k < b.size(); k++) begin
            for (int c = 0; c < cpb[d]; c++) begin
                @(negedge clk);
                rxd[d] = (k == spike_bit && c == spike_cyc) ? ~b[k] : b[k];
                ack[d] = (k == b.size() - 1) && (c == ack_cyc);
                if (g == rst_cyc) begin
                    rst    = 1'b1;
                    rxd[d] = 1'b1;
                    return;
                end
                g++;
            end
        end
    endtask

    initial begin
        logic [7:0] w;
        logic       p;
        logic [1:0] st;
        int         d;
        bit         do_a;

        for (int i = 0; i < N; i++) begin
            rxd[i] = 1'b1;
            ack[i] = 1'b0;
            model_clear(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) check_out(i, "reset");
        rst = 1'b0;
        idle(0, 4);

        // 8N1 0x5A
        send_frame(0, 8'h5A, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h5A, 1'b0, 2'b11, 0);
        idle(0, 2);
        check_out(0, "frame5a");
        do_ack(0, "frame5a");

        // 3-clk glitch on idle line
        @(negedge clk); rxd[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); rxd[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("glitch.busy_start", {31'd0, busy[0]}, 32'd1);
        idle(0, 2 * cpb[0]);
        check_out(0, "glitch");

        // parity cases
        send_frame(1, 8'h07, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(1, 8'h07, 1'b0, 2'b11, 0);
        idle(1, 2); check_out(1, "even_p0"); do_ack(1, "even_p0");
        chk_eq("even_p0.perr_model", {31'd0, perr[1]}, 32'd0);
        send_frame(1, 8'h07, 1'b1, 2'b11, -1, -1, -1, -1);
        model_commit(1, 8'h07, 1'b1, 2'b11, 0);
        idle(1, 2); check_out(1, "even_p1"); do_ack(1, "even_p1");
        send_frame(2, 8'h07, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(2, 8'h07, 1'b0, 2'b11, 0);
        idle(2, 2); check_out(2, "odd_p0"); do_ack(2, "odd_p0");

        // second stop bit low
        send_frame(1, 8'hC3, 1'b0, 2'b01, -1, -1, -1, -1);
        model_commit(1, 8'hC3, 1'b0, 2'b01, 0);
        idle(1, 2); check_out(1, "stop2low"); do_ack(1, "stop2low");

        // break: line stays low after an all-zero frame
        send_frame(1, 8'h00, 1'b0, 2'b00, -1, -1, -1, -1);
        model_commit(1, 8'h00, 1'b0, 2'b00, 0);
        repeat (2 * cpb[1]) begin @(negedge clk); rxd[1] = 1'b0; end
        chk_eq("break.valid", {31'd0, valid[1]}, 32'd1);
        chk_eq("break.ferr", {31'd0, ferr[1]}, 32'd1);
        chk_eq("break.data", dat(1), 32'd0);
        do_ack(1, "break");
        repeat (4 * cpb[1]) begin @(negedge clk); rxd[1] = 1'b0; end
        chk_eq("break.no_second", {31'd0, valid[1]}, 32'd0);
        chk_eq("break.not_busy", {31'd0, busy[1]}, 32'd0);
        idle(1, cpb[1]);

        // back-to-back, no ack -> overrun
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h11, 1'b0, 2'b11, 0);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h22, 1'b0, 2'b11, 0);
        idle(0, 2); check_out(0, "b2b_noack"); do_ack(0, "b2b_noack");

        // back-to-back, ack in the second commit cycle
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h11, 1'b0, 2'b11, 0);
        send_frame(0, 8'h22, 1'b0, 2'b11, cpb[0] / 2 + 3 + MAJ, -1, -1, -1);
        model_commit(0, 8'h22, 1'b0, 2'b11, 1);
        idle(0, 2); check_out(0, "b2b_ack"); do_ack(0, "b2b_ack");

        // reset mid-DATA with an unacked word held
        send_frame(0, 8'h55, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h55, 1'b0, 2'b11, 0);
        idle(0, 2); check_out(0, "pre_rst");
        send_frame(0, 8'hAA, 1'b0, 2'b11, -1, 4 * cpb[0] + 3, -1, -1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) model_clear(i);
        for (int i = 0; i < N; i++) check_out(i, "mid_rst");
        idle(0, 3);
        send_frame(0, 8'h3C, 1'b0, 2'b11, -1, -1, -1, -1);
        model_commit(0, 8'h3C, 1'b0, 2'b11, 0);
        idle(0, 2); check_out(0, "post_rst"); do_ack(0, "post_rst");

`ifdef UART_RX_MAJORITY_EN
        send_frame(0, 8'h3C, 1'b0, 2'b11, -1, -1, 3, cpb[0] / 2 + 1);
        model_commit(0, 8'h3C, 1'b0, 2'b11, 0);
        idle(0, 2); check_out(0, "spike"); do_ack(0, "spike");
`endif

        // randomized frames across all configurations
        for (int it = 0; it < 30; it++) begin
            d    = $urandom_range(0, N - 1);
            w    = 8'($urandom);
            p    = 1'($urandom);
            st   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            do_a = ($urandom_range(0, 3) != 0);
            send_frame(d, w, p, st, -1, -1, -1, -1);
            model_commit(d, w, p, st, 0);
            idle(d, 2);
            check_out(d, $sformatf("rnd%0d", it));
            if (do_a) do_ack(d, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
